// File: rtl/xpb_pkg.sv
// Shared constants and types for the xpb reduction table generator.
package xpb_pkg;

  localparam int XPB_WIDTH  = 1024;
  localparam int XPB_ADDR_W = 5;
  localparam int XPB_DEPTH  = 1 << XPB_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RED  = 2'd2
  } xpb_state_e;

  typedef logic [XPB_WIDTH-1:0] xpb_word_t;

endpackage

// File: rtl/xpb_modadd.sv
// Two-stage modular accumulator: sum = acc + v (one extra bit), then acc = sum mod n.
// Requires acc < n and v < n so a single conditional subtract is enough.
module xpb_modadd
  import xpb_pkg::*;
#(
  parameter int WIDTH = XPB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic             red_en,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign diff = sum - {1'b0, n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      acc <= '0;
    end else begin
      if (add_en) sum <= {1'b0, acc} + {1'b0, v};
      if (clr)
        acc <= '0;
      else if (red_en)
        acc <= (sum >= {1'b0, n}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/xpb_table_gen.sv
// Streams entry[j] = (j*V) mod N for j = 0..DEPTH-1, one entry every two cycles.
// Define XPB_GEN_LOCAL_RAM_EN to capture the stream in a local readable table RAM.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter  int WIDTH  = XPB_WIDTH,
  parameter  int ADDR_W = XPB_ADDR_W,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  modulus,
  input  logic [WIDTH-1:0]  base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              table_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
`ifdef XPB_GEN_LOCAL_RAM_EN
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
`endif
  output logic [WIDTH-1:0]  wr_data
);

  xpb_state_e        state_q, state_d;
  logic [WIDTH-1:0]  n_q, v_q;
  logic              accept, reject, go, last;
  logic              busy_d, done_d, err_d, tv_d, wr_en_d;
  logic [ADDR_W-1:0] addr_d;

  assign accept = (state_q == ST_IDLE) && start;
  assign reject = accept && (base >= modulus);
  assign go     = accept && !reject;
  // wr_addr holds the last written j; the RED step that writes DEPTH-1 ends the run
  assign last   = (wr_addr == ADDR_W'(DEPTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      v_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      table_valid <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      table_valid <= tv_d;
      wr_en       <= wr_en_d;
      wr_addr     <= addr_d;
      if (accept) begin
        n_q <= modulus;
        v_q <= base;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_ADD;
      ST_ADD:  state_d = ST_RED;
      ST_RED:  state_d = last ? ST_IDLE : ST_ADD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    tv_d    = table_valid;
    wr_en_d = 1'b0;
    addr_d  = wr_addr;
    case (state_q)
      ST_IDLE: begin
        if (reject) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (go) begin
          err_d   = 1'b0;
          tv_d    = 1'b0;
          busy_d  = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = '0;
        end
      end
      ST_RED: begin
        wr_en_d = 1'b1;
        addr_d  = wr_addr + ADDR_W'(1);
        if (last) begin
          done_d = 1'b1;
          tv_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // acc is cleared on accept so entry 0 appears as wr_data = 0 without a special case
  xpb_modadd #(.WIDTH(WIDTH)) u_modadd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (go),
    .add_en (state_q == ST_ADD),
    .red_en (state_q == ST_RED),
    .n      (n_q),
    .v      (v_q),
    .acc    (wr_data)
  );

`ifdef XPB_GEN_LOCAL_RAM_EN
  logic [WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= ram[rd_addr];
  end
`endif

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen at WIDTH=16: vector table plus hand-built corner sequences.
module tb_xpb_table_gen;

  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  modulus = '0;
  logic [W-1:0]  base = '0;
  logic          busy, done, err, table_valid, wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
`ifdef XPB_GEN_LOCAL_RAM_EN
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
`endif

  int  total = 0;
  int  bad = 0;
  bit  tv_exp = 1'b0;

  xpb_table_gen #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .modulus     (modulus),
    .base        (base),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .table_valid (table_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
`ifdef XPB_GEN_LOCAL_RAM_EN
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
`endif
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model(input int j, input logic [W-1:0] n, input logic [W-1:0] v);
    return (longint'(j) * longint'(v)) % longint'(n);
  endfunction

  typedef struct packed {
    logic [W-1:0]      n;
    logic [W-1:0]      v;
    logic              exp_err;
    logic [3:0][W-1:0] head;   // hand-computed entries 0..3
  } vec_t;

  // Runs one sequence for 70 cycles after E0; optional start pulse at cycle pulse_at.
  task automatic run_seq(input logic [W-1:0] n, input logic [W-1:0] v, input bit exp_err,
                         input int pulse_at, output logic [3:0][W-1:0] head);
    int nwr = 0;
    int ndone = 0;
    int done_cyc = -1;
    head    = '0;
    modulus = n;
    base    = v;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      check("busy", longint'(busy), longint'(!exp_err && cyc <= 62));
      if (wr_en) begin
        check("wr_addr", longint'(wr_addr), longint'(nwr));
        check("wr_data", longint'(wr_data), model(nwr, n, v));
        check("wr_cycle", longint'(cyc), longint'(1 + 2 * nwr));
        if (nwr < 4) head[nwr] = wr_data;
        nwr++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        check("err_at_done", longint'(err), longint'(exp_err));
      end
      start = (cyc == pulse_at);
      tick();
    end
    start = 1'b0;
    if (!exp_err) tv_exp = 1'b1;
    check("n_writes", longint'(nwr), exp_err ? 0 : 32);
    check("n_done", longint'(ndone), 1);
    check("done_cycle", longint'(done_cyc), exp_err ? 1 : 63);
    check("table_valid", longint'(table_valid), longint'(tv_exp));
    check("err_hold", longint'(err), longint'(exp_err));
  endtask

  vec_t vecs [6];
  logic [3:0][W-1:0] got;

  initial begin
    vecs[0] = '{n: 16'h1234, v: 16'h1234, exp_err: 1'b1, head: '0};
    vecs[1] = '{n: 16'h0000, v: 16'h0005, exp_err: 1'b1, head: '0};
    vecs[2] = '{n: 16'hFFF1, v: 16'h8000, exp_err: 1'b0,
                head: {16'h800F, 16'h000F, 16'h8000, 16'h0000}};
    vecs[3] = '{n: 16'h0011, v: 16'h0000, exp_err: 1'b0,
                head: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[4] = '{n: 16'hFFFF, v: 16'hFFFE, exp_err: 1'b0,
                head: {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'h0000}};
    vecs[5] = '{n: 16'h0007, v: 16'h0003, exp_err: 1'b0,
                head: {16'h0002, 16'h0006, 16'h0003, 16'h0000}};

    // reset state
    repeat (2) tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_tv", longint'(table_valid), 0);
    check("rst_wr_en", longint'(wr_en), 0);
    check("rst_wr_addr", longint'(wr_addr), 0);
    check("rst_wr_data", longint'(wr_data), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_seq(vecs[i].n, vecs[i].v, vecs[i].exp_err, -1, got);
      if (!vecs[i].exp_err)
        for (int k = 0; k < 4; k++)
          check($sformatf("head%0d_vec%0d", k, i), longint'(got[k]), longint'(vecs[i].head[k]));
    end

    // start pulsed mid-run is ignored
    run_seq(16'hFFF1, 16'h8000, 1'b0, 10, got);

    // start held high: new sequence begins the cycle after done
    begin
      bit seen = 1'b0;
      modulus = 16'h0007;
      base    = 16'h0003;
      start   = 1'b1;
      tick();
      for (int cyc = 1; cyc < 63; cyc++) tick();
      check("held_done63", longint'(done), 1);
      tick();
      check("held_restart_wr_en", longint'(wr_en), 1);
      check("held_restart_addr", longint'(wr_addr), 0);
      check("held_restart_busy", longint'(busy), 1);
      check("held_restart_tv", longint'(table_valid), 0);
      start = 1'b0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
        if (done) seen = 1'b1;
        else tick();
      end
      check("held_second_done", longint'(seen), 1);
      tv_exp = 1'b1;
      tick();
    end

    // asynchronous reset at cycle 20 of a run
    modulus = 16'hFFF1;
    base    = 16'h8000;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) tick();
    check("pre_rst_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_wr_en", longint'(wr_en), 0);
    check("mid_rst_tv", longint'(table_valid), 0);
    check("mid_rst_done", longint'(done), 0);
    tv_exp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_seq(16'hFFF1, 16'h8000, 1'b0, -1, got);
    check("post_rst_entry1", longint'(got[1]), 16'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
